m_memarb: RTL and testbench
===========================

# m_memarb

Single-port memory arbiter for a unified-memory build of the five-stage pipeline. It shares one `m_memory` instance (4K x 32-bit, registered read, write-first-cycle) between the IF-stage instruction port and the MEM-stage data port. Each cycle it grants the memory to at most one requester and drives the memory address, write-enable and data. It returns read data with a one-cycle valid pulse and holds it for stalled stages. It also produces the stall condition the pipeline controller uses to freeze IF.

## Interface
Parameters:
- ADDR_W, 12, word-address width (matches `m_memory`)
- STARVE_MAX, 3, consecutive lost conflicts after which the instruction port wins (1..15)

Ports:
- w_clk  in  1  clock, all state on posedge
- w_rst  in  1  reset; one clock, synchronous, active-high
- w_i_req  in  1  instruction read request
- w_i_addr  in  ADDR_W  instruction word address
- w_i_gnt  out  1  instruction request accepted this cycle
- r_i_rvalid  out  1  instruction read data valid (1-cycle pulse)
- w_i_rdata  out  32  instruction read data (live on rvalid, held otherwise)
- w_d_req  in  1  data request
- w_d_we  in  1  data request is a write
- w_d_addr  in  ADDR_W  data word address
- w_d_wdata  in  32  store data
- w_d_gnt  out  1  data request accepted this cycle
- r_d_rvalid  out  1  data read data valid (1-cycle pulse)
- w_d_rdata  out  32  data read data (live on rvalid, held otherwise)
- w_m_addr  out  ADDR_W  memory address
- w_m_we  out  1  memory write enable
- w_m_din  out  32  memory write data
- w_m_dout  in  32  memory registered read data
- r_conf  out  16  saturating count of cycles with both requests asserted

## Operation
- Grants are combinational from the current requests and state. Requester inputs must stay stable while their request is high and not yet granted.
- Single request: that port is granted.
- Both requests, default policy: the data port wins unless r_starve == STARVE_MAX, in which case the instruction port wins.
- r_starve (4 bits):
  - +1 on each cycle the instruction port loses a conflict, saturating at STARVE_MAX
  - cleared to 0 when the instruction port is granted or w_i_req is low
- Memory mux:
  - w_m_addr = granted port's address; with no grant it equals w_i_addr
  - w_m_we = w_d_gnt & w_d_we
  - w_m_din = w_d_wdata
- Read tracking:
  - r_i_pend is set on a granted instruction read; r_d_pend is set on a granted data read (not a write)
  - Both pend flags are cleared on any other cycle
  - rvalid outputs are the pend flags
- Hold registers:
  - r_i_hold loads w_m_dout in the cycle r_i_rvalid is 1; r_d_hold does the same on r_d_rvalid
  - w_x_rdata = r_x_rvalid ? w_m_dout : r_x_hold
- r_conf increments on each cycle with w_i_req & w_d_req and saturates at 16'hFFFF.
- The pipeline stalls IF when w_i_req & ~w_i_gnt. MEM stalls when w_d_req & ~w_d_gnt, which can only occur under a starvation override.

## Timing
- Grant: same cycle as the request (0 cycles).
- Read data: rvalid in cycle T+1 for a grant in cycle T; data is held from T+2 until the next rvalid for that port.
- Write: committed at the end of the granted cycle; no response pulse.
- Back-to-back grants to the same port are allowed every cycle (throughput 1/cycle total).
- A read to the address being written in the same cycle is impossible (single port). A data read the cycle after a write returns the new value.
- Reset values: r_i_rvalid = r_d_rvalid = 0, r_i_hold = r_d_hold = 0, r_starve = 0, r_conf = 0, RR pointer = data-preferred.
- While w_rst is high: w_i_gnt = w_d_gnt = 0 and w_m_we = 0.
- Reset mid-operation: a read granted in the cycle before reset still pulses rvalid in the reset cycle. A grant cannot occur in the reset cycle, so rvalid is 0 in the cycle after reset.

## Configuration
- MEMARB_RR_EN defined:
  - Conflicts use round-robin: a 1-bit r_last records the last conflict winner, and the other port wins the next conflict.
  - r_starve is held at 0 and STARVE_MAX is ignored.
- MEMARB_RR_EN undefined: fixed data priority with the starvation override described under Operation.

## Test plan
- Reset, then instruction reads only at addresses 0,1,2 on consecutive cycles -> w_i_gnt = 1 each cycle; r_i_rvalid = 1 at T+1 with w_i_rdata = memory contents; r_conf = 0.
- Data write 32'h20 to address 0, then data read of address 0 next cycle -> w_m_we = 1 only in the first cycle; r_d_rvalid = 1 two cycles after the write with w_d_rdata = 32'h20.
- Both ports request continuously for 8 cycles, default build, STARVE_MAX = 3 -> grant sequence D,D,D,I,D,D,D,I; r_conf = 8.
- Same stimulus with MEMARB_RR_EN -> grant sequence D,I,D,I,D,I,D,I.
- Instruction read granted, then w_i_req low for 3 cycles -> w_i_rdata holds the returned word for all 3 cycles; r_i_rvalid = 1 for exactly one cycle.
- w_rst asserted while a data read is pending and both requests are high -> rvalid still pulses in the reset cycle; no grant and w_m_we = 0 during reset; r_conf = 0 and r_starve = 0 afterward; rvalid = 0 in the cycle after reset.

Source files
------------

// File: rtl/m_memarb.sv
`default_nettype none
// ============================================================================
// Module   : m_memarb
// Purpose  : Single-port memory arbiter for the unified-memory pipeline.
//            Shares one registered-read memory between the IF-stage
//            instruction port and the MEM-stage data port. Grants are
//            combinational; read data returns one cycle after the grant as a
//            one-cycle valid pulse and is held afterwards for stalled stages.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Build option:
//   MEMARB_RR_EN  defined   -> conflicts are resolved round-robin (r_last)
//                 undefined -> data port wins conflicts, except that the
//                              instruction port wins once it has lost
//                              STARVE_MAX consecutive conflicts
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_W      word-address width of the shared memory
//   STARVE_MAX  consecutive lost conflicts before the instruction port wins
// Ports:
//   w_clk, w_rst                   clock, synchronous active-high reset
//   w_i_req/w_i_addr               instruction read request / address
//   w_i_gnt                        instruction request accepted this cycle
//   r_i_rvalid/w_i_rdata           instruction read data valid / data
//   w_d_req/w_d_we/w_d_addr        data request / write flag / address
//   w_d_wdata                      store data
//   w_d_gnt                        data request accepted this cycle
//   r_d_rvalid/w_d_rdata           data read data valid / data
//   w_m_addr/w_m_we/w_m_din        memory address / write enable / data in
//   w_m_dout                       memory registered read data
//   r_conf                         saturating count of conflict cycles
// ============================================================================
module m_memarb #(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic              w_clk,
  input  logic              w_rst,
  // instruction port
  input  logic              w_i_req,
  input  logic [ADDR_W-1:0] w_i_addr,
  output logic              w_i_gnt,
  output logic              r_i_rvalid,
  output logic [31:0]       w_i_rdata,
  // data port
  input  logic              w_d_req,
  input  logic              w_d_we,
  input  logic [ADDR_W-1:0] w_d_addr,
  input  logic [31:0]       w_d_wdata,
  output logic              w_d_gnt,
  output logic              r_d_rvalid,
  output logic [31:0]       w_d_rdata,
  // memory side
  output logic [ADDR_W-1:0] w_m_addr,
  output logic              w_m_we,
  output logic [31:0]       w_m_din,
  input  logic [31:0]       w_m_dout,
  // statistics
  output logic [15:0]       r_conf
);

  logic        w_conflict;
  logic        w_i_win;      // instruction port wins a conflict this cycle
  logic [31:0] r_i_hold;
  logic [31:0] r_d_hold;
  logic [3:0]  r_starve;

  assign w_conflict = w_i_req & w_d_req;

`ifdef MEMARB_RR_EN
  // r_last = 1 when the data port won the most recent conflict, so the
  // instruction port is next in line. Reset value 0 makes data preferred.
  logic r_last;

  assign w_i_win = r_last;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_last <= 1'b0;
    end else if (w_conflict) begin
      r_last <= w_d_gnt;
    end
  end

  // Starvation tracking is not used by the round-robin policy.
  always_ff @(posedge w_clk) begin
    r_starve <= 4'd0;
  end
`else
  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  assign w_i_win = (r_starve == c_STARVE_MAX);

  // Counts consecutive conflicts the instruction port has lost. Any cycle in
  // which it is granted, or is not requesting, restarts the count.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_starve <= 4'd0;
    end else if (!w_i_req || w_i_gnt) begin
      r_starve <= 4'd0;
    end else if (w_conflict && (r_starve != c_STARVE_MAX)) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Grants: nothing is granted while reset is held.
  // --------------------------------------------------------------------------
  assign w_i_gnt = ~w_rst & w_i_req & (~w_d_req |  w_i_win);
  assign w_d_gnt = ~w_rst & w_d_req & (~w_i_req | ~w_i_win);

  // --------------------------------------------------------------------------
  // Memory mux: the instruction address is the idle default so that the
  // address path only switches when the data port actually owns the memory.
  // --------------------------------------------------------------------------
  assign w_m_addr = w_d_gnt ? w_d_addr : w_i_addr;
  assign w_m_we   = w_d_gnt & w_d_we;
  assign w_m_din  = w_d_wdata;

  // --------------------------------------------------------------------------
  // Read tracking: the pend flags double as the rvalid outputs since the
  // memory returns data exactly one cycle after the granted address.
  // --------------------------------------------------------------------------
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_i_rvalid <= w_i_gnt;
      r_d_rvalid <= w_d_gnt & ~w_d_we;
    end
  end

  // Hold registers capture the returned word so that a stalled stage keeps
  // seeing it after the memory output moves on to another access.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_i_hold <= 32'd0;
      r_d_hold <= 32'd0;
    end else begin
      if (r_i_rvalid) begin
        r_i_hold <= w_m_dout;
      end
      if (r_d_rvalid) begin
        r_d_hold <= w_m_dout;
      end
    end
  end

  assign w_i_rdata = r_i_rvalid ? w_m_dout : r_i_hold;
  assign w_d_rdata = r_d_rvalid ? w_m_dout : r_d_hold;

  // --------------------------------------------------------------------------
  // Conflict counter, saturating.
  // --------------------------------------------------------------------------
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_conf <= 16'd0;
    end else if (w_conflict && (r_conf != 16'hFFFF)) begin
      r_conf <= r_conf + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_memarb.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_memarb
// Purpose  : Self-checking bench for m_memarb. Provides a registered-read,
//            write-first memory, a directed vector table, hand sequences for
//            hold and reset behaviour, and a randomized phase checked against
//            a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_m_memarb;

  localparam int AW = 12;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          i_gnt, d_gnt, i_rvalid, d_rvalid, m_we;
  logic [31:0]   i_rdata, d_rdata, m_din;
  logic [31:0]   m_dout = '0;
  logic [AW-1:0] m_addr;
  logic [15:0]   conf;

  always #5 clk = ~clk;

  m_memarb #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .w_clk(clk), .w_rst(rst),
    .w_i_req(i_req), .w_i_addr(i_addr), .w_i_gnt(i_gnt),
    .r_i_rvalid(i_rvalid), .w_i_rdata(i_rdata),
    .w_d_req(d_req), .w_d_we(d_we), .w_d_addr(d_addr), .w_d_wdata(d_wdata),
    .w_d_gnt(d_gnt), .r_d_rvalid(d_rvalid), .w_d_rdata(d_rdata),
    .w_m_addr(m_addr), .w_m_we(m_we), .w_m_din(m_din), .w_m_dout(m_dout),
    .r_conf(conf)
  );

  // Initial memory contents are a fixed pattern; written words overlay it.
  function automatic logic [31:0] pat(input int a);
    return 32'h1000_0000 + a * 32'h0000_0107;
  endfunction

  // Memory environment: registered read, write-first.
  logic [31:0] env_mem [0:(1<<AW)-1];
  bit          env_wr  [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (m_we) begin
      env_mem[m_addr] <= m_din;
      env_wr[m_addr]  <= 1'b1;
      m_dout          <= m_din;
    end else begin
      m_dout <= env_wr[m_addr] ? env_mem[m_addr] : pat(int'(m_addr));
    end
  end

  // ---------------------------------------------------------------- checking
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ----------------------------------------------------------- reference model
  logic [31:0] ref_mem [0:(1<<AW)-1];
  bit          ref_wr  [0:(1<<AW)-1];
  bit          mi_pend = 0, md_pend = 0;
  logic [31:0] mi_word = 0, md_word = 0, mi_hold = 0, md_hold = 0;
  int          m_conf = 0;
  int          m_lost = 0;         // consecutive conflicts lost by instruction port
  bit          m_last_was_d = 0;   // data won the previous conflict

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : pat(int'(a));
  endfunction

  // Values sampled from the DUT during the latest step.
  logic        s_gi, s_gd, s_we, s_iv, s_dv;
  logic [31:0] s_ird, s_drd;
  logic [15:0] s_conf;

  // One clock cycle: drive inputs at negedge, check at negedge+1, update model
  // at the following posedge.
  task automatic step(input logic r, input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dw, input logic [AW-1:0] da,
                      input logic [31:0] wd, input bit full);
    bit eig, edg, iwin;
    @(negedge clk);
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
    #1;
`ifdef MEMARB_RR_EN
    iwin = m_last_was_d;
`else
    iwin = (m_lost == SMAX);
`endif
    eig = !r && ir && (!dr || iwin);
    edg = !r && dr && (!ir || !iwin);
    s_gi = i_gnt; s_gd = d_gnt; s_we = m_we; s_iv = i_rvalid; s_dv = d_rvalid;
    s_ird = i_rdata; s_drd = d_rdata; s_conf = conf;
    chk("i_gnt", {31'd0, i_gnt}, {31'd0, eig});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
    chk("m_we", {31'd0, m_we}, {31'd0, edg && dw});
    chk("m_addr", {20'd0, m_addr}, {20'd0, (edg ? da : ia)});
    if (edg && dw) chk("m_din", m_din, wd);
    if (full) begin
      chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, mi_pend});
      chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, md_pend});
      chk("i_rdata", i_rdata, mi_pend ? mi_word : mi_hold);
      chk("d_rdata", d_rdata, md_pend ? md_word : md_hold);
      chk("conf", {16'd0, conf}, m_conf[31:0]);
    end
    @(posedge clk);
    if (r) begin
      mi_pend = 0; md_pend = 0; mi_hold = 0; md_hold = 0;
      m_conf = 0; m_lost = 0; m_last_was_d = 0;
    end else begin
      if (mi_pend) mi_hold = mi_word;
      if (md_pend) md_hold = md_word;
      mi_pend = eig;
      if (eig) mi_word = ref_rd(ia);
      md_pend = edg && !dw;
      if (md_pend) md_word = ref_rd(da);
      if (edg && dw) begin ref_mem[da] = wd; ref_wr[da] = 1; end
      if (ir && dr && m_conf < 65535) m_conf++;
      if (!ir || eig) m_lost = 0;
      else if (ir && dr && m_lost < SMAX) m_lost++;
      if (ir && dr) m_last_was_d = edg;
    end
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    logic          r, ir;
    logic [AW-1:0] ia;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [31:0]   wd;
    logic          egi, egd, ewe, eiv, edv;
    logic          cdr;
    logic [31:0]   edr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic ir, input int ia, input logic dr, input logic dw,
                              input int da, input logic [31:0] wd,
                              input logic egi, input logic egd, input logic ewe,
                              input logic eiv, input logic edv,
                              input logic cdr, input logic [31:0] edr);
    vec_t v;
    v.r = 0; v.ir = ir; v.ia = AW'(ia); v.dr = dr; v.dw = dw; v.da = AW'(da); v.wd = wd;
    v.egi = egi; v.egd = egd; v.ewe = ewe; v.eiv = eiv; v.edv = edv;
    v.cdr = cdr; v.edr = edr;
    return v;
  endfunction

  initial begin
    bit          gi_seq[8];
    bit          hi, hd;
    logic        r_r, r_ir, r_dr, r_dw;
    logic [AW-1:0] r_ia, r_da;
    logic [31:0] r_wd;
    int          ivc;

    // instruction reads at 0,1,2 then idle
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // data write 0x20 to 0, read back next cycle
    tv.push_back(mk(0, 0, 1, 1, 0, 32'h20, 0, 1, 1, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 1, 1, 32'h20));
    tv.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1, 32'h20));
    // both ports requesting for 8 cycles
    for (int k = 0; k < 8; k++) begin
`ifdef MEMARB_RR_EN
      gi_seq[k] = (k % 2 == 1);
`else
      gi_seq[k] = (k % 4 == 3);
`endif
      tv.push_back(mk(1, 5, 1, 0, 9, 0, gi_seq[k], !gi_seq[k], 0,
                      (k > 0) && gi_seq[k-1], (k > 0) && !gi_seq[k-1], 0, 0));
    end
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, gi_seq[7], !gi_seq[7], 0, 0));

    for (int k = 0; k < (1 << AW); k++) begin
      ref_wr[k] = 0; ref_mem[k] = 0;
    end

    // reset
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_conf", {16'd0, s_conf}, 32'd0);
    chk("reset_i_rvalid", {31'd0, s_iv}, 32'd0);
    chk("reset_d_rdata", s_drd, 32'd0);

    foreach (tv[n]) begin
      step(tv[n].r, tv[n].ir, tv[n].ia, tv[n].dr, tv[n].dw, tv[n].da, tv[n].wd, 1);
      chk($sformatf("tv%0d_i_gnt", n), {31'd0, s_gi}, {31'd0, tv[n].egi});
      chk($sformatf("tv%0d_d_gnt", n), {31'd0, s_gd}, {31'd0, tv[n].egd});
      chk($sformatf("tv%0d_m_we", n), {31'd0, s_we}, {31'd0, tv[n].ewe});
      chk($sformatf("tv%0d_i_rvalid", n), {31'd0, s_iv}, {31'd0, tv[n].eiv});
      chk($sformatf("tv%0d_d_rvalid", n), {31'd0, s_dv}, {31'd0, tv[n].edv});
      if (tv[n].cdr) chk($sformatf("tv%0d_d_rdata", n), s_drd, tv[n].edr);
      if (n == 1) chk("tv1_i_rdata", s_ird, pat(0));
    end
    chk("conf_after_8_conflicts", {16'd0, s_conf}, 32'd8);

    // hold: one instruction read of address 7, then request low for 3 cycles
    step(0, 1, 7, 0, 0, 0, 0, 1);
    ivc = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1);
      chk($sformatf("hold%0d_i_rdata", k), s_ird, pat(7));
      ivc += int'(s_iv);
    end
    chk("hold_rvalid_pulses", ivc, 1);

    // reset while a data read is pending and both requests are high
    step(0, 0, 0, 1, 0, 3, 0, 1);
    step(1, 1, 5, 1, 1, 3, 32'hDEAD_BEEF, 1);
    chk("rst_d_rvalid", {31'd0, s_dv}, 32'd1);
    chk("rst_d_rdata", s_drd, pat(3));
    chk("rst_gnt", {30'd0, s_gi, s_gd}, 32'd0);
    chk("rst_m_we", {31'd0, s_we}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 5, 1, 0, 4, 0, 1);
      if (k == 0) begin
        chk("post_rst_d_rvalid", {31'd0, s_dv}, 32'd0);
        chk("post_rst_i_rvalid", {31'd0, s_iv}, 32'd0);
        chk("post_rst_conf", {16'd0, s_conf}, 32'd0);
      end
`ifdef MEMARB_RR_EN
      chk($sformatf("post_rst_gnt%0d", k), {31'd0, s_gi}, {31'd0, k[0]});
`else
      chk($sformatf("post_rst_gnt%0d", k), {31'd0, s_gi}, {31'd0, (k == 3)});
`endif
    end

    // randomized phase; ungranted requests keep their inputs stable
    r_ir = 0; r_dr = 0; r_dw = 0; r_ia = 0; r_da = 0; r_wd = 0;
    hi = 0; hd = 0;
    for (int c = 0; c < 600; c++) begin
      r_r = ($urandom_range(0, 39) == 0);
      if (!hi) begin
        r_ir = ($urandom_range(0, 3) != 0);
        r_ia = AW'($urandom_range(0, 15));
      end
      if (!hd) begin
        r_dr = ($urandom_range(0, 2) != 0);
        r_dw = $urandom_range(0, 1) == 1;
        r_da = AW'($urandom_range(0, 15));
        r_wd = $urandom;
      end
      step(r_r, r_ir, r_ia, r_dr, r_dw, r_da, r_wd, 1);
      hi = r_ir && !s_gi;
      hd = r_dr && !s_gd;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
